// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: W stage owns the port, long-latency results wait in a small FIFO.
// Optional macro WB_ARB_BYPASS_EN lets an lu write use a free port in its acceptance cycle.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  output logic        pend_rs,
  output logic        pend_rt,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        stall_req
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;
  logic [CW-1:0]    w_tail;
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] w_vld_n;
  logic [4:0]       r_reg   [DEPTH];
  logic [4:0]       w_reg_n [DEPTH];
  logic [31:0]      r_dat   [DEPTH];
  logic [31:0]      w_dat_n [DEPTH];
  logic [7:0]       r_age;
  logic [7:0]       w_age_n;
  logic             r_stall;

  logic w_wact;
  logic w_empty;
  logic w_full;
  logic w_head_vld;
  logic w_acc;
  logic w_byp;
  logic w_push;
  logic w_pop;
  logic w_wr_head;

  assign w_wact     = RegWriteW && (WriteRegW != 5'd0);
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_head_vld = !w_empty && r_vld[0];

  assign lu_ready   = rst && !w_full;
  assign w_acc      = lu_valid && lu_ready;

`ifdef WB_ARB_BYPASS_EN
  assign w_byp      = w_acc && (lu_reg != 5'd0) && w_empty && !w_wact;
`else
  assign w_byp      = 1'b0;
`endif

  assign w_push     = w_acc && (lu_reg != 5'd0) && !w_byp;
  // An invalidated head needs no port slot, so it drains even while W is writing.
  assign w_pop      = !w_empty && (!w_wact || !r_vld[0]);
  assign w_wr_head  = w_head_vld && !w_wact;
  assign w_tail     = r_cnt - CW'(w_pop);

  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    if (rst) begin
      if (w_wact) begin
        WE3 = 1'b1;
        A3  = WriteRegW;
        WD3 = ResultW;
      end else if (w_byp) begin
        WE3 = 1'b1;
        A3  = lu_reg;
        WD3 = lu_data;
      end else if (w_wr_head) begin
        WE3 = 1'b1;
        A3  = r_reg[0];
        WD3 = r_dat[0];
      end
    end
  end

  always_comb begin
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_reg[i] == RsD)) pend_rs = 1'b1;
      if (r_vld[i] && (r_reg[i] == RtD)) pend_rt = 1'b1;
    end
    if (!rst || (RsD == 5'd0)) pend_rs = 1'b0;
    if (!rst || (RtD == 5'd0)) pend_rt = 1'b0;
  end

  // Order: invalidate against W, shift out the head, then append at the post-pop tail.
  always_comb begin
    w_vld_n = r_vld;
    w_reg_n = r_reg;
    w_dat_n = r_dat;
    if (w_wact) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_reg[i] == WriteRegW) w_vld_n[i] = 1'b0;
      end
    end
    if (w_pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        w_vld_n[i] = w_vld_n[i+1];
        w_reg_n[i] = r_reg[i+1];
        w_dat_n[i] = r_dat[i+1];
      end
      w_vld_n[DEPTH-1] = 1'b0;
    end
    if (w_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_tail) begin
          w_vld_n[i] = 1'b1;
          w_reg_n[i] = lu_reg;
          w_dat_n[i] = lu_data;
        end
      end
    end
    w_cnt_n = r_cnt + CW'(w_push) - CW'(w_pop);
  end

  always_comb begin
    w_age_n = r_age;
    if (w_pop) begin
      w_age_n = '0;
    end else if (w_head_vld && (r_age != 8'(STARVE_LIMIT))) begin
      w_age_n = r_age + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_vld   <= '0;
      r_age   <= '0;
      r_stall <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_reg[i] <= '0;
        r_dat[i] <= '0;
      end
    end else begin
      r_cnt   <= w_cnt_n;
      r_vld   <= w_vld_n;
      r_reg   <= w_reg_n;
      r_dat   <= w_dat_n;
      r_age   <= w_age_n;
      r_stall <= w_full || (r_age == 8'(STARVE_LIMIT));
    end
  end

  assign stall_req = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  RsD, RtD;
  logic        pend_rs, pend_rt;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        stall_req;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .RsD(RsD), .RtD(RtD), .pend_rs(pend_rs), .pend_rt(pend_rt),
    .WE3(WE3), .A3(A3), .WD3(WD3), .stall_req(stall_req)
  );

  typedef struct { logic [4:0] r; logic [31:0] d; bit v; } ent_t;
  ent_t q[$];
  int   age;
  bit   m_stall;
  int   total = 0;
  int   bad   = 0;

  logic        e_we, e_rdy, e_prs, e_prt;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;

  function automatic bit wact();
    return RegWriteW && (WriteRegW != 5'd0);
  endfunction

  // Expected combinational outputs for the current inputs and model contents.
  task automatic calc();
    e_we = 1'b0; e_a3 = '0; e_wd = '0; e_prs = 1'b0; e_prt = 1'b0;
    e_rdy = rst && (q.size() < DEPTH);
    if (rst) begin
      if (wact()) begin
        e_we = 1'b1; e_a3 = WriteRegW; e_wd = ResultW;
      end
`ifdef WB_ARB_BYPASS_EN
      else if (q.size() == 0 && lu_valid && lu_reg != 5'd0) begin
        e_we = 1'b1; e_a3 = lu_reg; e_wd = lu_data;
      end
`endif
      else if (q.size() > 0 && q[0].v) begin
        e_we = 1'b1; e_a3 = q[0].r; e_wd = q[0].d;
      end
      foreach (q[i]) begin
        if (q[i].v && q[i].r == RsD && RsD != 5'd0) e_prs = 1'b1;
        if (q[i].v && q[i].r == RtD && RtD != 5'd0) e_prt = 1'b1;
      end
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, return at the next negedge.
  task automatic tick();
    bit acc, byp, pop, headv, nstall;
    @(posedge clk);
    if (!rst) begin
      q.delete(); age = 0; m_stall = 1'b0;
    end else begin
      acc    = lu_valid && (q.size() < DEPTH);
      byp    = 1'b0;
`ifdef WB_ARB_BYPASS_EN
      byp    = acc && lu_reg != 5'd0 && q.size() == 0 && !wact();
`endif
      nstall = (q.size() == DEPTH) || (age == LIMIT);
      headv  = (q.size() > 0) && q[0].v;
      pop    = (q.size() > 0) && (!wact() || !q[0].v);
      if (wact()) foreach (q[i]) if (q[i].r == WriteRegW) q[i].v = 1'b0;
      if (pop) begin
        void'(q.pop_front());
        age = 0;
      end else if (headv) begin
        age = (age < LIMIT) ? age + 1 : LIMIT;
      end
      if (acc && lu_reg != 5'd0 && !byp) q.push_back('{lu_reg, lu_data, 1'b1});
      m_stall = nstall;
    end
    @(negedge clk);
  endtask

  task automatic drv(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                     input logic [4:0] rs, input logic [4:0] rt);
    RegWriteW = rw; WriteRegW = wr; ResultW = wd;
    lu_valid = lv; lu_reg = lr; lu_data = ld; RsD = rs; RtD = rt;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    drv(1, 5'd3, 32'hDEAD, 1, 5'd4, 32'h55, 5'd4, 5'd3);
    total++;
    if ({WE3, A3, WD3, lu_ready, pend_rs, pend_rt, stall_req} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {WE3, A3, WD3, lu_ready, pend_rs, pend_rt, stall_req});
    end
    tick();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (lu_ready !== 1'b1 || WE3 !== 1'b0 || stall_req !== 1'b0) begin
      bad++; $display("FAIL reset_release: rdy=%b we=%b stall=%b want 1 0 0", lu_ready, WE3, stall_req);
    end
    tick();
  endtask

  task automatic test_lu_latency();
    drv(0, 0, 0, 1, 5'd5, 32'h1234, 5'd5, 0);
    total++;
`ifdef WB_ARB_BYPASS_EN
    if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h1234) begin
      bad++; $display("FAIL lu_bypass: we=%b a3=%0d wd=%h want 1 5 1234", WE3, A3, WD3);
    end
`else
    if (WE3 !== 1'b0 || lu_ready !== 1'b1) begin
      bad++; $display("FAIL lu_accept: we=%b rdy=%b want 0 1", WE3, lu_ready);
    end
`endif
    tick();
    drv(0, 0, 0, 0, 0, 0, 5'd5, 0);
`ifndef WB_ARB_BYPASS_EN
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h1234 || pend_rs !== 1'b1) begin
      bad++; $display("FAIL lu_latency: we=%b a3=%0d wd=%h prs=%b want 1 5 1234 1", WE3, A3, WD3, pend_rs);
    end
`endif
    tick();
    drv(0, 0, 0, 0, 0, 0, 5'd5, 0);
    total++;
    if (WE3 !== 1'b0 || pend_rs !== 1'b0) begin
      bad++; $display("FAIL lu_drained: we=%b prs=%b want 0 0", WE3, pend_rs);
    end
    tick();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 8; k++) begin
      drv(1, 5'(k + 1), $urandom, (k < 2), (k == 0) ? 5'd9 : 5'd10, 32'h900 + k, 0, 0);
      total++;
      if (WE3 !== 1'b1 || A3 !== 5'(k + 1) || lu_ready !== (k < 2)) begin
        bad++; $display("FAIL bp_cycle%0d: we=%b a3=%0d rdy=%b want 1 %0d %b", k, WE3, A3, lu_ready, k + 1, k < 2);
      end
      if (k >= 3) begin
        total++;
        if (stall_req !== 1'b1) begin bad++; $display("FAIL bp_stall%0d: got %b want 1", k, stall_req); end
      end
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'h900) begin
      bad++; $display("FAIL bp_drain_r9: we=%b a3=%0d wd=%h want 1 9 900", WE3, A3, WD3);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd10 || WD3 !== 32'h901) begin
      bad++; $display("FAIL bp_drain_r10: we=%b a3=%0d wd=%h want 1 10 901", WE3, A3, WD3);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (WE3 !== 1'b0 || lu_ready !== 1'b1) begin
      bad++; $display("FAIL bp_empty: we=%b rdy=%b want 0 1", WE3, lu_ready);
    end
    idle(2);
  endtask

  task automatic test_invalidate();
    drv(1, 5'd1, 32'h11, 1, 5'd7, 32'hAAAA, 0, 5'd7);
    tick();
    drv(1, 5'd7, 32'hBBBB, 0, 0, 0, 0, 5'd7);
    total++;
    if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'hBBBB || pend_rt !== 1'b1) begin
      bad++; $display("FAIL inv_w_write: we=%b a3=%0d wd=%h prt=%b want 1 7 bbbb 1", WE3, A3, WD3, pend_rt);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 5'd7);
      total++;
      if (WE3 !== 1'b0 || pend_rt !== 1'b0) begin
        bad++; $display("FAIL inv_no_stale%0d: we=%b a3=%0d wd=%h prt=%b want 0 0", k, WE3, A3, WD3, pend_rt);
      end
      tick();
    end
  endtask

  task automatic test_starve();
    drv(1, 5'd1, 32'h1, 1, 5'd12, 32'hC0C0, 0, 0);
    tick();
    for (int c = 1; c <= 13; c++) begin
      if (c <= 10) drv(1, 5'd2, 32'h2, 0, 0, 0, 0, 0);
      else         drv(0, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (stall_req !== (c >= 10 && c <= 12)) begin
        bad++; $display("FAIL starve_c%0d: stall=%b want %b", c, stall_req, (c >= 10 && c <= 12));
      end
      if (c == 11) begin
        total++;
        if (WE3 !== 1'b1 || A3 !== 5'd12 || WD3 !== 32'hC0C0) begin
          bad++; $display("FAIL starve_pop: we=%b a3=%0d wd=%h want 1 12 c0c0", WE3, A3, WD3);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    drv(1, 5'd1, 32'h1, 1, 5'd20, 32'h2020, 0, 0);
    tick();
    drv(1, 5'd2, 32'h2, 1, 5'd21, 32'h2121, 0, 0);
    tick();
    drv(1, 5'd3, 32'h3, 1, 5'd22, 32'h2222, 5'd20, 5'd21);
    total++;
    if (lu_ready !== 1'b0 || pend_rs !== 1'b1 || pend_rt !== 1'b1) begin
      bad++; $display("FAIL mid_full: rdy=%b prs=%b prt=%b want 0 1 1", lu_ready, pend_rs, pend_rt);
    end
    #2 rst = 1'b0;
    #1;
    q.delete(); age = 0; m_stall = 1'b0;
    total++;
    if ({WE3, A3, WD3, lu_ready, pend_rs, pend_rt, stall_req} !== '0) begin
      bad++; $display("FAIL mid_reset: got %h want 0", {WE3, A3, WD3, lu_ready, pend_rs, pend_rt, stall_req});
    end
    @(negedge clk);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
      total++;
      if (lu_ready !== 1'b1 || WE3 !== 1'b0 || pend_rs !== 1'b0 || pend_rt !== 1'b0) begin
        bad++; $display("FAIL mid_after%0d: rdy=%b we=%b prs=%b prt=%b want 1 0 0 0", k, lu_ready, WE3, pend_rs, pend_rt);
      end
      tick();
    end
  endtask

  task automatic test_r0();
    for (int k = 0; k < 3; k++) begin
      drv(1, 5'd0, $urandom, 1, 5'd0, $urandom, 0, 0);
      total++;
      if (WE3 !== 1'b0 || lu_ready !== 1'b1 || stall_req !== 1'b0) begin
        bad++; $display("FAIL r0_cycle%0d: we=%b rdy=%b stall=%b want 0 1 0", k, WE3, lu_ready, stall_req);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      drv(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      calc();
      total++;
      if ({WE3, A3, WD3} !== {e_we, e_a3, e_wd}) begin
        bad++; $display("FAIL rnd_port n=%0d: got %b/%0d/%h want %b/%0d/%h", n, WE3, A3, WD3, e_we, e_a3, e_wd);
      end
      total++;
      if (lu_ready !== e_rdy) begin
        bad++; $display("FAIL rnd_ready n=%0d: got %b want %b", n, lu_ready, e_rdy);
      end
      total++;
      if ({pend_rs, pend_rt} !== {e_prs, e_prt}) begin
        bad++; $display("FAIL rnd_pend n=%0d: got %b%b want %b%b", n, pend_rs, pend_rt, e_prs, e_prt);
      end
      total++;
      if (stall_req !== m_stall) begin
        bad++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, stall_req, m_stall);
      end
      tick();
    end
  endtask

  initial begin
    age = 0; m_stall = 1'b0;
    RegWriteW = 0; WriteRegW = 0; ResultW = 0;
    lu_valid = 0; lu_reg = 0; lu_data = 0; RsD = 0; RtD = 0;
    test_reset();
    test_lu_latency();
    test_backpressure();
    test_invalidate();
    test_starve();
    test_reset_midstream();
    test_r0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, defines the number of deferred-write buffer entries (legal 1..4).
REQ-002 Parameter STARVE_LIMIT, default 8, defines the head-entry wait cycles before stall_req asserts (legal 1..255).
REQ-003 clk  in  1  pipeline clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 RegWriteW, WriteRegW, ResultW  in  1/5/32  writeback-stage write request, register and data.
REQ-006 lu_valid, lu_reg, lu_data  in  1/5/32  long-latency unit write request, register and data.
REQ-007 lu_ready  out  1  arbiter accepts the lu write this cycle.
REQ-008 RsD, RtD  in  5/5  decode-stage source register numbers.
REQ-009 pend_rs, pend_rt  out  1/1  a buffered write targets RsD or RtD respectively.
REQ-010 WE3, A3, WD3  out  1/5/32  register-file write port.
REQ-011 stall_req  out  1  request to the hazard logic to freeze fetch/decode.

Function
REQ-012 The W request is active when RegWriteW=1 and WriteRegW!=0, and it SHALL always own the write port in the same cycle (WE3=1, A3=WriteRegW, WD3=ResultW, combinational).
REQ-013 When the W request is inactive and the buffer is non-empty, the port SHALL write the buffer head and pop it at the clock edge.
REQ-014 When neither source writes, the port SHALL drive WE3=0, A3=0 and WD3=0.
REQ-015 lu_ready SHALL be 1 exactly when the registered entry count is below DEPTH; a same-cycle pop SHALL NOT raise lu_ready.
REQ-016 An lu write is accepted when lu_valid and lu_ready are both 1; if lu_reg=0 it SHALL be accepted and discarded.
REQ-017 An accepted lu write SHALL be enqueued at the tail; simultaneous push and pop SHALL keep the count unchanged while preserving FIFO order.
REQ-018 When the W request is active and a buffered entry has a register equal to WriteRegW, that entry SHALL be invalidated (W is program-newer); invalid entries SHALL be popped without writing, at one entry per cycle.
REQ-019 pend_rs SHALL be 1 when RsD!=0 and any valid entry matches RsD; pend_rt SHALL be defined the same way for RtD. Both are combinational.
REQ-020 A head-age counter SHALL increment each cycle a valid head entry is not written, clear on every pop, and saturate at STARVE_LIMIT.
REQ-021 stall_req SHALL be 1 when the count equals DEPTH or the head age equals STARVE_LIMIT; it SHALL be registered, asserting one cycle after the condition and deasserting one cycle after the condition clears.
REQ-022 The wait from lu acceptance to the write-port write SHALL be at least 1 cycle, and exactly 1 cycle when the port is free (unless WB_ARB_BYPASS_EN applies).

Reset
REQ-023 While rst=0, the block SHALL empty the buffer, clear the head age, and drive stall_req=0, lu_ready=0, WE3=0, A3=0, WD3=0, pend_rs=0 and pend_rt=0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL discard all buffered writes without any port write; after release lu_ready=1 on the first cycle.

Configuration
REQ-025 With macro WB_ARB_BYPASS_EN defined, an accepted lu write with lu_reg!=0, an empty buffer and an inactive W request SHALL be written to the port in the same cycle and not enqueued.
REQ-026 Without WB_ARB_BYPASS_EN, every accepted lu write SHALL pass through the buffer, giving a latency of at least 1 cycle.

Verification
REQ-027 Scenario 1: with the buffer empty and W idle, apply lu write r5=0x1234 -> WE3=1, A3=5, WD3=0x1234 one cycle later (same cycle with bypass); pend_rs=1 during the wait when RsD=5 (bypass off).
REQ-028 Scenario 2: hold W writing r1..r8 for 8 cycles while lu pushes r9 and r10 -> lu_ready=0 after 2 pushes; stall_req=1 on the next cycle; r9 then r10 are written in the 2 cycles after W goes idle.
REQ-029 Scenario 3: buffer r7=0xAAAA, then W writes r7=0xBBBB -> the entry is invalidated; r7 is never written with 0xAAAA; pend_rt deasserts with RtD=7.
REQ-030 Scenario 4: buffer one entry with W busy for 10 cycles -> stall_req rises 9 cycles after enqueue (age 8 plus register) and falls one cycle after the pop.
REQ-031 Scenario 5: with the buffer full, pull rst low mid-stream -> all outputs are 0 immediately; after release lu_ready=1, and no stale write appears.
REQ-032 Scenario 6: lu write to r0 and W write to r0 -> WE3 stays 0, the count stays 0, and lu_ready stays 1.
